// File: rtl/radix4_mult_ctrl_param_if.sv
// Operand-load / compute handshake bundle between the board side and the
// radix-4 multiplier controller. Widths derive from WIDTH and CHUNK.
interface radix4_mult_ctrl_param_if #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int NITER  = WIDTH / 2;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW     = (NITER > 1) ? $clog2(NITER) : 1;

  logic          start_i;
  logic          get_i;
  logic          reuse_b_i;
  logic          a_ld_o;
  logic          b_ld_o;
  logic [CW-1:0] chunk_sel_o;
  logic          pr_rst_o;
  logic          last_bit_o;
  logic          pr_ld_o;
  logic          shift_en_o;
  logic [IW-1:0] iter_o;
  logic          busy_o;
  logic          ready_o;

  modport master (
    output start_i, get_i, reuse_b_i,
    input  a_ld_o, b_ld_o, chunk_sel_o, pr_rst_o, last_bit_o,
           pr_ld_o, shift_en_o, iter_o, busy_o, ready_o
  );

  modport slave (
    input  start_i, get_i, reuse_b_i,
    output a_ld_o, b_ld_o, chunk_sel_o, pr_rst_o, last_bit_o,
           pr_ld_o, shift_en_o, iter_o, busy_o, ready_o
  );
endinterface

// File: rtl/radix4_mult_ctrl_param.sv
// Radix-4 Booth multiplier controller: loads A and B chunk-wise over a level
// get handshake, then runs WIDTH/2 iterations and pulses ready.
module radix4_mult_ctrl_param #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  radix4_mult_ctrl_param_if.slave      bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int NITER  = WIDTH / 2;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW     = (NITER > 1) ? $clog2(NITER) : 1;

  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);
  localparam logic [IW-1:0] LAST_ITER  = IW'(NITER - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT_A = 3'd1;
  localparam logic [2:0] S_LD_A   = 3'd2;
  localparam logic [2:0] S_WAIT_B = 3'd3;
  localparam logic [2:0] S_LD_B   = 3'd4;
  localparam logic [2:0] S_INIT   = 3'd5;
  localparam logic [2:0] S_CALC   = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] chunk_q, chunk_d;
  logic [IW-1:0] iter_q,  iter_d;
  logic          reuse_q, reuse_d;
  logic          bval_q,  bval_d;

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    iter_d  = iter_q;
    reuse_d = reuse_q;
    bval_d  = bval_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_WAIT_A;
          chunk_d = '0;
          reuse_d = bus.reuse_b_i & bval_q;
        end
      end
      S_WAIT_A: if (bus.get_i) state_d = S_LD_A;
      S_LD_A: begin
        // A chunk completes on the falling get; the last one skips B when reusing
        if (!bus.get_i) begin
          if (chunk_q < LAST_CHUNK) begin
            chunk_d = chunk_q + 1'b1;
            state_d = S_WAIT_A;
          end else begin
            chunk_d = '0;
            state_d = reuse_q ? S_INIT : S_WAIT_B;
          end
        end
      end
      S_WAIT_B: if (bus.get_i) state_d = S_LD_B;
      S_LD_B: begin
        if (!bus.get_i) begin
          if (chunk_q < LAST_CHUNK) begin
            chunk_d = chunk_q + 1'b1;
            state_d = S_WAIT_B;
          end else begin
            chunk_d = '0;
            bval_d  = 1'b1;
            state_d = S_INIT;
          end
        end
      end
      S_INIT: begin
        iter_d  = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        if (iter_q == LAST_ITER) begin
          iter_d  = '0;
          state_d = S_DONE;
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      chunk_q <= '0;
      iter_q  <= '0;
      reuse_q <= 1'b0;
      bval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      iter_q  <= iter_d;
      reuse_q <= reuse_d;
      bval_q  <= bval_d;
    end
  end

  assign bus.a_ld_o      = (state_q == S_LD_A);
  assign bus.b_ld_o      = (state_q == S_LD_B);
  assign bus.chunk_sel_o = chunk_q;
  assign bus.pr_rst_o    = (state_q == S_INIT);
  assign bus.last_bit_o  = (state_q == S_INIT);
  assign bus.pr_ld_o     = (state_q == S_CALC);
  assign bus.shift_en_o  = (state_q == S_CALC);
  assign bus.iter_o      = (state_q == S_CALC) ? iter_q : '0;
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.ready_o     = (state_q == S_DONE);
endmodule

// File: tb/tb_radix4_mult_ctrl_param.sv
// Scoreboard bench for radix4_mult_ctrl_param: a 16/8 instance and an 8/8 instance.
module tb_radix4_mult_ctrl_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  radix4_mult_ctrl_param_if #(.WIDTH(16), .CHUNK(8)) if0 ();
  radix4_mult_ctrl_param_if #(.WIDTH(8),  .CHUNK(8)) if1 ();

  radix4_mult_ctrl_param #(.WIDTH(16), .CHUNK(8)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  radix4_mult_ctrl_param #(.WIDTH(8),  .CHUNK(8)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  typedef struct {
    int a0; int a1; int b0; int b1; int calc; int busy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_errors = 0;

  int acc_a[2][2];
  int acc_b[2][2];
  int acc_prr[2], acc_lb[2], acc_calc[2], acc_bad[2], acc_rdy[2], acc_busy[2];
  bit prev_busy[2];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_acc(input int d);
    acc_a[d][0] = 0; acc_a[d][1] = 0; acc_b[d][0] = 0; acc_b[d][1] = 0;
    acc_prr[d] = 0; acc_lb[d] = 0; acc_calc[d] = 0; acc_bad[d] = 0;
    acc_rdy[d] = 0; acc_busy[d] = 0;
  endtask

  task automatic mon(input int d, input bit r, input bit ald, input bit bld, input int cs,
                     input bit prr, input bit lb, input bit prl, input bit se, input int it,
                     input bit bsy, input bit rdy);
    exp_t e;
    if (r) begin
      clear_acc(d);
      prev_busy[d] = 1'b0;
      return;
    end
    if (bsy) begin
      if (!prev_busy[d]) clear_acc(d);
      acc_busy[d]++;
      if (ald) acc_a[d][cs]++;
      if (bld) acc_b[d][cs]++;
      if (prr) acc_prr[d]++;
      if (lb)  acc_lb[d]++;
      if (prl) begin
        if (it != acc_calc[d] || acc_prr[d] != 1) acc_bad[d]++;
        acc_calc[d]++;
      end else if (it != 0) begin
        acc_bad[d]++;
      end
      if (prl != se) acc_bad[d]++;
      if (rdy) acc_rdy[d]++;
    end else if (prev_busy[d] && acc_rdy[d] > 0) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        check($sformatf("d%0d_unexpected_op", d), 1, 0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("d%0d_a_ld_c0", d), acc_a[d][0], e.a0);
        check($sformatf("d%0d_a_ld_c1", d), acc_a[d][1], e.a1);
        check($sformatf("d%0d_b_ld_c0", d), acc_b[d][0], e.b0);
        check($sformatf("d%0d_b_ld_c1", d), acc_b[d][1], e.b1);
        check($sformatf("d%0d_pr_rst", d), acc_prr[d], 1);
        check($sformatf("d%0d_last_bit", d), acc_lb[d], 1);
        check($sformatf("d%0d_calc_len", d), acc_calc[d], e.calc);
        check($sformatf("d%0d_iter_seq", d), acc_bad[d], 0);
        check($sformatf("d%0d_ready_len", d), acc_rdy[d], 1);
        check($sformatf("d%0d_busy_len", d), acc_busy[d], e.busy);
      end
    end
    prev_busy[d] = bsy;
  endtask

  always @(negedge clk) begin
    mon(0, rst, if0.a_ld_o, if0.b_ld_o, int'(if0.chunk_sel_o), if0.pr_rst_o, if0.last_bit_o,
        if0.pr_ld_o, if0.shift_en_o, int'(if0.iter_o), if0.busy_o, if0.ready_o);
    mon(1, rst, if1.a_ld_o, if1.b_ld_o, int'(if1.chunk_sel_o), if1.pr_rst_o, if1.last_bit_o,
        if1.pr_ld_o, if1.shift_en_o, int'(if1.iter_o), if1.busy_o, if1.ready_o);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int d, input bit s, input bit g, input bit rb);
    if (d == 0) begin
      if0.start_i = s; if0.get_i = g; if0.reuse_b_i = rb;
    end else begin
      if1.start_i = s; if1.get_i = g; if1.reuse_b_i = rb;
    end
  endtask

  task automatic chk_zero(input int d, input string tag);
    if (d == 0)
      check(tag, int'({if0.a_ld_o, if0.b_ld_o, if0.chunk_sel_o, if0.pr_rst_o, if0.last_bit_o,
                       if0.pr_ld_o, if0.shift_en_o, if0.iter_o, if0.busy_o, if0.ready_o}), 0);
    else
      check(tag, int'({if1.a_ld_o, if1.b_ld_o, if1.chunk_sel_o, if1.pr_rst_o, if1.last_bit_o,
                       if1.pr_ld_o, if1.shift_en_o, if1.iter_o, if1.busy_o, if1.ready_o}), 0);
  endtask

  // One operation: start, then nch get pulses (first hi0 cycles high, rest hi),
  // each preceded by one low cycle; expectations are queued up front.
  task automatic do_op(input int d, input bit reuse, input int nch, input int hi0,
                       input int hi, input bit abort, input bit poke);
    exp_t e;
    int   niter, nck, h, slot;
    bit   rb;
    bit   bsy;
    niter = (d == 0) ? 8 : 4;
    nck   = (d == 0) ? 2 : 1;
    e.a0 = 0; e.a1 = 0; e.b0 = 0; e.b1 = 0;
    e.calc = niter;
    e.busy = 2 + hi0 + hi * (nch - 1) + (nch - 1) + 2 + niter;
    for (int k = 0; k < nch; k++) begin
      h = (k == 0) ? hi0 : hi;
      slot = (k < nck) ? k : (k - nck + 2);
      case (slot)
        0: e.a0 = h;
        1: e.a1 = h;
        2: e.b0 = h;
        default: e.b1 = h;
      endcase
    end
    if (!abort) begin
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    drv(d, 1'b1, 1'b0, reuse);
    tick();
    rb = 1'($urandom_range(0, 1));
    drv(d, 1'b0, 1'b0, rb);
    for (int k = 0; k < nch; k++) begin
      tick();
      drv(d, 1'b0, 1'b1, rb);
      repeat ((k == 0) ? hi0 : hi) tick();
      drv(d, 1'b0, 1'b0, rb);
    end
    if (poke) begin
      tick();
      tick();
      drv(d, 1'b1, 1'b0, rb);
      tick();
      drv(d, 1'b0, 1'b0, rb);
    end
    if (abort) begin
      for (int i = 0; i < 40; i++) begin
        if (if0.pr_ld_o && if0.iter_o == 3'd3) break;
        tick();
      end
      check("reach_iter3", int'({if0.pr_ld_o, if0.iter_o}), 8 + 3);
      rst = 1'b1;
      #1;
      chk_zero(0, "mid_reset_zero");
      tick();
      tick();
      rst = 1'b0;
      drv(d, 1'b0, 1'b0, 1'b0);
      tick();
      return;
    end
    for (int i = 0; i < 40; i++) begin
      bsy = (d == 0) ? if0.busy_o : if1.busy_o;
      if (!bsy) break;
      tick();
    end
    bsy = (d == 0) ? if0.busy_o : if1.busy_o;
    check($sformatf("d%0d_done_timeout", d), int'(bsy), 0);
    drv(d, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    drv(0, 1'b0, 1'b0, 1'b0);
    drv(1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drv(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      chk_zero(0, "d0_reset_zero");
      chk_zero(1, "d1_reset_zero");
    end
    drv(0, 1'b0, 1'b0, 1'b0);
    drv(1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) tick();
    chk_zero(0, "d0_idle_after_reset");
    chk_zero(1, "d1_idle_after_reset");

    // reuse_b requested before any B load: full four-chunk load expected
    do_op(0, 1'b1, 4, 2, 2, 1'b0, 1'b0);
    // plain full operation
    do_op(0, 1'b0, 4, 2, 2, 1'b0, 1'b0);
    // reuse B: only two A chunks
    do_op(0, 1'b1, 2, 2, 2, 1'b0, 1'b0);
    // abort at iter 3, then reuse must again be ignored
    do_op(0, 1'b0, 4, 2, 2, 1'b1, 1'b0);
    do_op(0, 1'b1, 4, 2, 2, 1'b0, 1'b0);

    // 8/8: single chunk held 5 cycles, start poked during CALC
    do_op(1, 1'b0, 2, 5, 2, 1'b0, 1'b1);
    repeat (3) tick();
    check("d1_start_in_calc_ignored", int'(if1.busy_o), 0);
    do_op(1, 1'b1, 1, 3, 0, 1'b0, 1'b0);

    repeat (3) tick();
    check("d0_queue_empty", q0.size(), 0);
    check("d1_queue_empty", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/radix4_mult_ctrl_param.md
# radix4_mult_ctrl_param

Parametrised control unit for the radix-4 (Booth) multiplier datapath. It sequences operand loading over a narrow input bus in `CHUNK`-bit pieces using a level `get` handshake. It then runs exactly `WIDTH/2` radix-4 iterations and pulses `ready`. New in this generation: any operand width and chunk width, an exposed iteration index, a `busy` flag, and a `reuse_b` mode that skips reloading B. The block sits between the board/input interface and the multiplier datapath (operand registers, partial-product register, shifter).

## Interface
- `WIDTH`, 16, operand width in bits; must be even.
- `CHUNK`, 8, input chunk width; must divide `WIDTH`. Derived values:
  - `NCHUNK = WIDTH/CHUNK`
  - `NITER = WIDTH/2`
  - `CW = max(1, clog2(NCHUNK))`
  - `IW = max(1, clog2(NITER))`
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin operation; sampled in IDLE only.
- `get`  in  1  level handshake; each high-then-low excursion transfers one chunk.
- `reuse_b`  in  1  sampled with `start`; 1 = keep the previously loaded B.
- `a_ld`  out  1  load A chunk `chunk_sel` from the input bus.
- `b_ld`  out  1  load B chunk `chunk_sel` from the input bus.
- `chunk_sel`  out  CW  chunk index, 0 = least significant.
- `pr_rst`  out  1  clear the partial-product register.
- `last_bit`  out  1  clear the Booth extra (B[-1]) bit.
- `pr_ld`  out  1  load the partial-product register.
- `shift_en`  out  1  shift the multiplier by 2.
- `iter`  out  IW  current iteration index; valid in CALC, 0 elsewhere.
- `busy`  out  1  high in every state except IDLE.
- `ready`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, WAIT_A, LD_A, WAIT_B, LD_B, INIT, CALC, DONE.
- Outputs are Moore decodes of state plus the chunk and iteration counters.
- IDLE:
  - If `start`=1, go to WAIT_A with `chunk_sel`=0.
  - Latch `reuse_eff = reuse_b & b_valid`.
- WAIT_A:
  - Stay while `get`=0.
  - When `get`=1, go to LD_A.
- LD_A:
  - `a_ld`=1 every cycle while `get`=1; this repeated load is harmless.
  - When `get`=0:
    - If `chunk_sel` < NCHUNK-1, increment it and return to WAIT_A.
    - Else clear `chunk_sel` and go to WAIT_B, or to INIT if `reuse_eff`=1.
- WAIT_B / LD_B:
  - Identical to WAIT_A / LD_A but assert `b_ld`.
  - After the last chunk, set `b_valid`=1 and go to INIT.
- INIT (1 cycle):
  - `pr_rst`=1 and `last_bit`=1.
  - Iteration counter cleared; go to CALC.
- CALC:
  - `pr_ld`=1 and `shift_en`=1 every cycle; `iter` counts 0..NITER-1.
  - After the cycle with `iter`=NITER-1, go to DONE.
  - CALC lasts exactly NITER cycles.
- DONE (1 cycle):
  - `ready`=1.
  - `busy` stays 1 in DONE and drops to 0 when the FSM returns to IDLE.
  - Go to IDLE.
- `b_valid`:
  - Internal flag, cleared only by reset.
  - `reuse_b` is ignored until B has been loaded once.
- Ignored inputs:
  - `start` outside IDLE.
  - `get` in IDLE, INIT, CALC and DONE.
  - `reuse_b` outside IDLE.

## Timing
- Reset (asynchronous, immediate, also mid-operation):
  - State goes to IDLE.
  - `chunk_sel`=0, `iter`=0, `b_valid`=0.
  - All 1-bit outputs are 0.
  - Any partially loaded operand is abandoned.
- `start` high at edge k puts the FSM in WAIT_A from cycle k+1.
- `get` rising sampled at edge t: LD_A from t+1, with `a_ld` high for as many cycles as `get` stays high.
- `get` low sampled at edge u: next WAIT state from u+1.
- A 1-cycle `get` pulse yields exactly one `a_ld` cycle.
- From leaving the last LD state: INIT 1 cycle, then CALC NITER cycles, then DONE 1 cycle.
- Compute latency is NITER+2 cycles.
- `ready` at cycle DONE; a new `start` is accepted no earlier than the following IDLE cycle.
- NCHUNK=1 edge case: `chunk_sel` is stuck at 0, and each LD state exits after its single chunk.

## Test plan
- Reset values:
  - Assert `rst` for 3 cycles with random inputs.
  - All outputs must be 0 and `busy`=0.
  - Release `rst`; the FSM stays in IDLE with `start`=0.
- Full operation (16/8):
  - `start`, then 4 `get` pulses of 2 cycles each.
  - `a_ld` for 2 cycles at `chunk_sel`=0, then 0→1.
  - `b_ld` likewise at 0, then 1.
  - `pr_rst`/`last_bit` for 1 cycle.
  - `pr_ld`/`shift_en` for exactly 8 cycles with `iter` 0..7.
  - `ready` for exactly 1 cycle; `busy` high from start+1 through DONE.
- Reuse B:
  - After the full operation above, `start` with `reuse_b`=1 and 2 `get` pulses.
  - INIT follows the second A chunk.
  - `b_ld` never asserts; CALC lasts 8 cycles.
- Reuse ignored:
  - Right after reset, `start` with `reuse_b`=1.
  - The FSM still waits for 4 chunks; `b_ld` asserts for chunks 0 and 1.
- Mid-operation reset:
  - Assert `rst` during CALC at `iter`=3.
  - All outputs go to 0 in the same cycle.
  - The next operation requires a full 4-chunk load (`b_valid` was cleared).
- WIDTH=8, CHUNK=8:
  - `get` held for 5 cycles gives `a_ld` for 5 cycles and counts as a single chunk.
  - One B chunk follows.
  - CALC lasts 4 cycles with `iter` 0..3.
  - `start` pulsed during CALC is ignored.
